syn_btb_sa: RTL and testbench
=============================

# syn_btb_sa

Parametrised set-associative branch target buffer. Each entry holds a full-PC tag, an N-bit saturating direction counter, a target address and a per-set LRU age. The block sits in IF beside the PC register. Lookup is combinational: it produces `hit` and the next-fetch guess in the same cycle. Resolved branches from EX/MEM update it on the clock edge. It replaces the fixed 8-entry fully-associative table with configurable sets, ways and counter width, gated allocation and a flush.

## Interface
- `IM_ADDR_BIT`, 10, instruction word-address width
- `SETS`, 4, number of sets (power of two, ≥1); `IDX_BIT = log2(SETS)`, 0 when `SETS=1`
- `WAYS`, 2, ways per set (power of two, 1..8)
- `CTR_BIT`, 2, direction counter width (≥1)
- `clk`  in  1  clock, all state updates on rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `en`  in  1  global stall gate; 0 freezes all state
- `flush`  in  1  invalidate whole table
- `PC`  in  IM_ADDR_BIT  fetch address being looked up
- `PC_4`  in  IM_ADDR_BIT  sequential next address
- `w_en`  in  1  resolved branch present this cycle
- `succeed`  in  1  resolved branch was taken
- `pc_before_g`  in  IM_ADDR_BIT  address of resolved branch
- `g_addr`  in  IM_ADDR_BIT  resolved taken target
- `hit`  out  1  PC found in table
- `guess_addr`  out  IM_ADDR_BIT  predicted next fetch address

## Operation
- Set index is `addr[IDX_BIT-1:0]`. The tag is the full `IM_ADDR_BIT` address.
- Lookup is purely combinational:
  - `hit` = any valid way in set(PC) has tag == PC.
  - `guess_addr` = that way's target if its counter MSB = 1, else `PC_4`.
  - On a miss, `guess_addr` = `PC_4`.
  - If tags are ever duplicated, the lowest way wins.
- Update occurs when `en && w_en && !flush`, at the rising edge:
  - **Tag hit in set(pc_before_g):**
    - Counter increments when `succeed=1` and decrements otherwise, saturating at 0 and 2^CTR_BIT−1.
    - The target is written with `g_addr` only when `succeed=1`.
    - The way becomes MRU.
  - **Tag miss, `succeed=1`:** allocate a victim.
    - Victim is the lowest-index invalid way, else the way with age == WAYS−1.
    - Write valid=1, tag=`pc_before_g`, target=`g_addr`, counter=2^(CTR_BIT−1) (weakly taken).
    - The victim becomes MRU.
  - **Tag miss, `succeed=0`:** no state change (not-taken branches never allocate).
- LRU ages:
  - Each set keeps distinct ages 0..WAYS−1.
  - On touch of way w: ages less than age[w] increment, and age[w] becomes 0. Other ages are unchanged.
  - Only updates touch LRU; lookups do not.
- `flush` (when `en`, rising edge):
  - All valid bits clear.
  - Ages reload to age[way]=way in every set.
  - Counters and targets are don't-care.
  - `flush` has priority over a simultaneous update, which is dropped.
- `rst_n` low does the same as flush, immediately and asynchronously, regardless of `en`. Targets, tags and counters need no reset.

## Timing
- Lookup latency is 0 cycles, combinational from PC/PC_4 to `hit` and `guess_addr`.
- Update and flush take effect at the rising edge. They are visible to lookups in the following cycle.
- There is no forwarding: a same-cycle lookup of `pc_before_g` sees the pre-update state.
- With `en=0`, no state changes and outputs still track PC combinationally.
- Outputs during and after reset: `hit=0`, `guess_addr=PC_4` until the first allocation.
- Reset asserted mid-update aborts the write. The table is empty after the reset release edge.
- Counter arithmetic is `CTR_BIT` wide and saturating with no wrap. Ages are `log2(WAYS)` bits.

## Test plan
- **Reset/empty lookup:** release reset, then look up PC=0x004 with PC_4=0x005 → `hit=0`, `guess_addr=0x005`.
- **Allocate then predict:**
  - Update pc_before_g=0x004, succeed=1, g_addr=0x040.
  - Next cycle, PC=0x004 → `hit=1`, `guess_addr=0x040` (counter=2).
  - Three not-taken updates → counter saturates at 0, `guess_addr=PC_4`, `hit` stays 1.
- **Not-taken miss:** update pc_before_g=0x008, succeed=0 → next-cycle lookup of 0x008 gives `hit=0`. Confirm no other entry was changed.
- **LRU replacement (SETS=4, WAYS=2):**
  - Allocate 0x010 (→0x100), then 0x020 (→0x200); both land in set 0.
  - Update 0x010 taken.
  - Allocate 0x030.
  - Result: 0x020 is evicted (`hit=0`); 0x010 and 0x030 both hit.
- **Flush vs update collision:** with 0x010 valid, assert `flush` and an update of 0x050 in the same cycle → next cycle all lookups miss, including 0x050.
- **Stall and async reset:**
  - Update with `en=0` → no allocation.
  - Drop `rst_n` mid-cycle after allocations → `hit` falls to 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/syn_btb_sa_if.sv
// Fetch-side lookup and resolve-side update bundle for the set-associative BTB.
// master = pipeline (drives PC and resolved branch), slave = BTB (returns prediction).
interface syn_btb_sa_if #(
    parameter int IM_ADDR_BIT = 10
);
    logic                   en;
    logic                   flush;
    logic [IM_ADDR_BIT-1:0] PC;
    logic [IM_ADDR_BIT-1:0] PC_4;
    logic                   w_en;
    logic                   succeed;
    logic [IM_ADDR_BIT-1:0] pc_before_g;
    logic [IM_ADDR_BIT-1:0] g_addr;
    logic                   hit;
    logic [IM_ADDR_BIT-1:0] guess_addr;

    modport master (
        output en, flush, PC, PC_4, w_en, succeed, pc_before_g, g_addr,
        input  hit, guess_addr
    );

    modport slave (
        input  en, flush, PC, PC_4, w_en, succeed, pc_before_g, g_addr,
        output hit, guess_addr
    );
endinterface

// File: rtl/syn_btb_sa.sv
// Set-associative BTB: 0-cycle combinational lookup, update/flush on rising edge.
// No backpressure; en=0 freezes all state while lookup keeps tracking PC.
module syn_btb_sa #(
    parameter int IM_ADDR_BIT = 10,
    parameter int SETS        = 4,
    parameter int WAYS        = 2,
    parameter int CTR_BIT     = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    syn_btb_sa_if.slave  bus
);
    localparam int IDX_BIT = (SETS > 1) ? $clog2(SETS) : 0;
    localparam int AGE_BIT = (WAYS > 1) ? $clog2(WAYS) : 1;

    typedef logic [IM_ADDR_BIT-1:0] addr_t;
    typedef logic [AGE_BIT-1:0]     age_t;
    typedef logic [CTR_BIT-1:0]     ctr_t;

    localparam ctr_t CTR_MAX  = {CTR_BIT{1'b1}};
    localparam ctr_t CTR_WEAK = ctr_t'(1) << (CTR_BIT - 1);

    logic  valid_q [SETS][WAYS];
    logic  valid_d [SETS][WAYS];
    age_t  age_q   [SETS][WAYS];
    age_t  age_d   [SETS][WAYS];
    addr_t tag_q   [SETS][WAYS];
    addr_t tgt_q   [SETS][WAYS];
    ctr_t  ctr_q   [SETS][WAYS];

    function automatic int set_of(input addr_t a);
        if (IDX_BIT == 0) return 0;
        return int'(a) & (SETS - 1);
    endfunction

    // Lookup: iterate high to low so the lowest matching way wins.
    int   lk_set;
    int   lk_way;
    logic lk_hit;
    always_comb begin
        lk_set = set_of(bus.PC);
        lk_hit = 1'b0;
        lk_way = 0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (valid_q[lk_set][w] && tag_q[lk_set][w] == bus.PC) begin
                lk_hit = 1'b1;
                lk_way = w;
            end
        end
    end

    assign bus.hit        = lk_hit;
    assign bus.guess_addr = (lk_hit && ctr_q[lk_set][lk_way][CTR_BIT-1])
                            ? tgt_q[lk_set][lk_way] : bus.PC_4;

    int   up_set;
    int   up_way;
    int   victim;
    int   touch_way;
    logic up_hit;
    logic have_inv;
    logic up_go;
    logic touch;
    always_comb begin
        up_set   = set_of(bus.pc_before_g);
        up_hit   = 1'b0;
        up_way   = 0;
        have_inv = 1'b0;
        victim   = 0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (valid_q[up_set][w] && tag_q[up_set][w] == bus.pc_before_g) begin
                up_hit = 1'b1;
                up_way = w;
            end
        end
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid_q[up_set][w]) begin
                have_inv = 1'b1;
                victim   = w;
            end
        end
        if (!have_inv) begin
            for (int w = 0; w < WAYS; w++) begin
                if (age_q[up_set][w] == age_t'(WAYS - 1)) victim = w;
            end
        end
        up_go     = bus.en && bus.w_en && !bus.flush;
        touch     = up_go && (up_hit || bus.succeed);
        touch_way = up_hit ? up_way : victim;
    end

    always_comb begin
        valid_d = valid_q;
        age_d   = age_q;
        if (bus.en && bus.flush) begin
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < WAYS; w++) begin
                    valid_d[s][w] = 1'b0;
                    age_d[s][w]   = age_t'(w);
                end
            end
        end else if (touch) begin
            valid_d[up_set][touch_way] = 1'b1;
            for (int w = 0; w < WAYS; w++) begin
                if (w == touch_way)
                    age_d[up_set][w] = '0;
                else if (age_q[up_set][w] < age_q[up_set][touch_way])
                    age_d[up_set][w] = age_q[up_set][w] + age_t'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < WAYS; w++) begin
                    valid_q[s][w] <= 1'b0;
                    age_q[s][w]   <= age_t'(w);
                end
            end
        end else begin
            valid_q <= valid_d;
            age_q   <= age_d;
        end
    end

    // Payload needs no reset: it is only observed through a valid bit.
    always_ff @(posedge clk) begin
        if (touch) begin
            if (up_hit) begin
                if (bus.succeed) begin
                    tgt_q[up_set][touch_way] <= bus.g_addr;
                    if (ctr_q[up_set][touch_way] != CTR_MAX)
                        ctr_q[up_set][touch_way] <= ctr_q[up_set][touch_way] + ctr_t'(1);
                end else if (ctr_q[up_set][touch_way] != '0) begin
                    ctr_q[up_set][touch_way] <= ctr_q[up_set][touch_way] - ctr_t'(1);
                end
            end else begin
                tag_q[up_set][touch_way] <= bus.pc_before_g;
                tgt_q[up_set][touch_way] <= bus.g_addr;
                ctr_q[up_set][touch_way] <= CTR_WEAK;
            end
        end
    end
endmodule

// File: tb/tb_syn_btb_sa.sv
// Directed bench for syn_btb_sa (SETS=4, WAYS=2, CTR_BIT=2): table of update/lookup rows plus
// hand sequences for same-cycle lookup, async reset and reset-aborted update.
module tb_syn_btb_sa;
    localparam int AW = 10;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    syn_btb_sa_if #(.IM_ADDR_BIT(AW)) bif();

    syn_btb_sa #(.IM_ADDR_BIT(AW), .SETS(4), .WAYS(2), .CTR_BIT(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bif)
    );

    typedef struct {
        logic          en;
        logic          flush;
        logic          w_en;
        logic          succeed;
        logic [AW-1:0] pbg;
        logic [AW-1:0] gaddr;
        logic [AW-1:0] look;
        logic          exp_hit;
        logic [AW-1:0] exp_guess;
    } vec_t;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%03h want 0x%03h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        bif.en = 1'b1; bif.flush = 1'b0; bif.w_en = 1'b0; bif.succeed = 1'b0;
        bif.pc_before_g = '0; bif.g_addr = '0;
    endtask

    vec_t vecs[$];

    function automatic vec_t mk(input logic en, input logic fl, input logic we, input logic sc,
                                input logic [AW-1:0] pbg, input logic [AW-1:0] ga,
                                input logic [AW-1:0] look, input logic eh, input logic [AW-1:0] eg);
        vec_t v;
        v.en = en; v.flush = fl; v.w_en = we; v.succeed = sc; v.pbg = pbg; v.gaddr = ga;
        v.look = look; v.exp_hit = eh; v.exp_guess = eg;
        return v;
    endfunction

    initial begin
        //                en fl we sc pbg     g_addr  look    hit guess
        vecs.push_back(mk(1, 0, 1, 1, 10'h004, 10'h040, 10'h004, 1, 10'h040)); // alloc, ctr=2
        vecs.push_back(mk(1, 0, 1, 0, 10'h004, 10'h3FF, 10'h004, 1, 10'h005)); // ctr=1
        vecs.push_back(mk(1, 0, 1, 0, 10'h004, 10'h3FF, 10'h004, 1, 10'h005)); // ctr=0
        vecs.push_back(mk(1, 0, 1, 0, 10'h004, 10'h3FF, 10'h004, 1, 10'h005)); // saturate at 0
        vecs.push_back(mk(1, 0, 1, 1, 10'h004, 10'h044, 10'h004, 1, 10'h005)); // ctr=1, tgt 0x044
        vecs.push_back(mk(1, 0, 1, 1, 10'h004, 10'h048, 10'h004, 1, 10'h048)); // ctr=2
        vecs.push_back(mk(1, 0, 1, 0, 10'h008, 10'h080, 10'h008, 0, 10'h009)); // not-taken miss
        vecs.push_back(mk(1, 0, 0, 0, 10'h000, 10'h000, 10'h004, 1, 10'h048)); // untouched
        vecs.push_back(mk(1, 1, 0, 0, 10'h000, 10'h000, 10'h004, 0, 10'h005)); // flush
        vecs.push_back(mk(1, 0, 1, 1, 10'h010, 10'h100, 10'h010, 1, 10'h100));
        vecs.push_back(mk(1, 0, 1, 1, 10'h020, 10'h200, 10'h020, 1, 10'h200));
        vecs.push_back(mk(1, 0, 1, 1, 10'h010, 10'h100, 10'h010, 1, 10'h100)); // 0x010 MRU
        vecs.push_back(mk(1, 0, 1, 1, 10'h030, 10'h300, 10'h030, 1, 10'h300)); // evicts 0x020
        vecs.push_back(mk(1, 0, 0, 0, 10'h000, 10'h000, 10'h020, 0, 10'h021));
        vecs.push_back(mk(1, 0, 0, 0, 10'h000, 10'h000, 10'h010, 1, 10'h100));
        vecs.push_back(mk(1, 0, 1, 1, 10'h011, 10'h111, 10'h011, 1, 10'h111)); // set 1
        vecs.push_back(mk(1, 0, 0, 0, 10'h000, 10'h000, 10'h030, 1, 10'h300));
        vecs.push_back(mk(1, 1, 1, 1, 10'h050, 10'h150, 10'h050, 0, 10'h051)); // flush beats update
        vecs.push_back(mk(1, 0, 0, 0, 10'h000, 10'h000, 10'h010, 0, 10'h011));
        vecs.push_back(mk(1, 0, 0, 0, 10'h000, 10'h000, 10'h011, 0, 10'h012));
        vecs.push_back(mk(0, 0, 1, 1, 10'h060, 10'h160, 10'h060, 0, 10'h061)); // stalled update
        vecs.push_back(mk(1, 0, 1, 1, 10'h060, 10'h160, 10'h060, 1, 10'h160));
        vecs.push_back(mk(0, 1, 0, 0, 10'h000, 10'h000, 10'h060, 1, 10'h160)); // stalled flush

        idle_inputs();
        bif.PC = 10'h004; bif.PC_4 = 10'h005;
        rst_n = 1'b0;
        #1;
        check("rst_hit", AW'(bif.hit), AW'(0));
        check("rst_guess", bif.guess_addr, 10'h005);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("empty_hit", AW'(bif.hit), AW'(0));
        check("empty_guess", bif.guess_addr, 10'h005);

        foreach (vecs[i]) begin
            @(negedge clk);
            bif.en = vecs[i].en; bif.flush = vecs[i].flush; bif.w_en = vecs[i].w_en;
            bif.succeed = vecs[i].succeed; bif.pc_before_g = vecs[i].pbg; bif.g_addr = vecs[i].gaddr;
            @(posedge clk);
            #1;
            idle_inputs();
            bif.PC = vecs[i].look; bif.PC_4 = vecs[i].look + AW'(1);
            #1;
            check($sformatf("row%0d_hit", i), AW'(bif.hit), AW'(vecs[i].exp_hit));
            check($sformatf("row%0d_guess", i), bif.guess_addr, vecs[i].exp_guess);
        end

        // Same-cycle lookup of the branch being written sees the old state.
        @(negedge clk);
        bif.w_en = 1'b1; bif.succeed = 1'b1; bif.pc_before_g = 10'h070; bif.g_addr = 10'h170;
        bif.PC = 10'h070; bif.PC_4 = 10'h071;
        #1;
        check("fwd_pre_hit", AW'(bif.hit), AW'(0));
        @(posedge clk);
        #1;
        idle_inputs();
        #1;
        check("fwd_post_hit", AW'(bif.hit), AW'(1));
        check("fwd_post_guess", bif.guess_addr, 10'h170);

        // Async reset drops hit with no clock edge.
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_hit", AW'(bif.hit), AW'(0));
        check("async_guess", bif.guess_addr, 10'h071);

        // Update held across an edge while in reset must not land.
        bif.w_en = 1'b1; bif.succeed = 1'b1; bif.pc_before_g = 10'h070; bif.g_addr = 10'h170;
        @(posedge clk);
        @(negedge clk);
        idle_inputs();
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rstabort_hit", AW'(bif.hit), AW'(0));
        bif.PC = 10'h060; bif.PC_4 = 10'h061;
        #1;
        check("rstempty_hit", AW'(bif.hit), AW'(0));
        check("rstempty_guess", bif.guess_addr, 10'h061);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
